// File: rtl/rice_core_pkg.sv
// Shared register-index types for the rice core, plus a macro that stamps out
// the XLEN-dependent value type inside each module that needs it.
`ifndef RICE_CORE_PKG_SV
`define RICE_CORE_PKG_SV

`define RICE_CORE_DEFINE_TYPES(XLEN_P) \
    typedef logic [(XLEN_P)-1:0] value_t;

package rice_core_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0]  busy_vec_t;

endpackage

`endif

// File: rtl/rice_core_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, and the
// hazard query for the instruction currently waiting in decode.
module rice_core_scoreboard
    import rice_core_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_set_en,
    input  reg_idx_t i_set_rd,
    input  logic     i_ex_valid,
    input  reg_idx_t i_ex_rd,
    input  logic     i_flush_clr_en,
    input  reg_idx_t i_flush_rd,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    input  reg_idx_t i_rd,
    input  logic     i_rd_write,
    output logic     o_hazard_c
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;

    // Clears first, then the new reservation, so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (i_ex_valid) begin
            busy_d[i_ex_rd] = 1'b0;
        end
        if (i_flush_clr_en) begin
            busy_d[i_flush_rd] = 1'b0;
        end
        if (i_set_en) begin
            busy_d[i_set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    logic fwd_rs1;
    logic fwd_rs2;
    logic ex_hits_rd;

    always_comb begin
        fwd_rs1    = i_ex_valid && (i_ex_rd == i_rs1) && (i_rs1 != '0);
        fwd_rs2    = i_ex_valid && (i_ex_rd == i_rs2) && (i_rs2 != '0);
        ex_hits_rd = i_ex_valid && (i_ex_rd == i_rd);
        o_hazard_c = (busy_q[i_rs1] && !fwd_rs1)
                  || (busy_q[i_rs2] && !fwd_rs2)
                  || (i_rd_write && (i_rd != '0) && busy_q[i_rd] && !ex_hits_rd);
    end

endmodule

// File: rtl/rice_core_operand_fetch.sv
// Operand fetch stage: reads sources with EX forwarding, stalls on pending
// writes, and holds one instruction in an output register toward EX.
module rice_core_operand_fetch
    import rice_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_id_valid,
    output logic                               o_id_ready,
    input  logic [REG_IDX_W-1:0]               i_id_rs1,
    input  logic [REG_IDX_W-1:0]               i_id_rs2,
    input  logic [REG_IDX_W-1:0]               i_id_rd,
    input  logic                               i_id_rd_write,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      i_register_file,
    input  logic                               i_ex_valid,
    input  logic [REG_IDX_W-1:0]               i_ex_rd,
    input  logic [XLEN-1:0]                    i_ex_rd_value,
    input  logic                               i_flush,
    output logic                               o_of_valid,
    input  logic                               i_of_ready,
    output logic [XLEN-1:0]                    o_of_rs1_value,
    output logic [XLEN-1:0]                    o_of_rs2_value,
    output logic [REG_IDX_W-1:0]               o_of_rd,
    output logic                               o_of_rd_write
);

    `RICE_CORE_DEFINE_TYPES(XLEN)

    logic     of_valid_q;
    value_t   rs1_value_q;
    value_t   rs2_value_q;
    reg_idx_t rd_q;
    logic     rd_write_q;

    logic     hazard_c;
    logic     id_ready_c;
    logic     accept_c;
    value_t   rs1_value_c;
    value_t   rs2_value_c;

    rice_core_scoreboard u_scoreboard (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_set_en       (accept_c && i_id_rd_write),
        .i_set_rd       (i_id_rd),
        .i_ex_valid     (i_ex_valid),
        .i_ex_rd        (i_ex_rd),
        .i_flush_clr_en (i_flush && of_valid_q && rd_write_q),
        .i_flush_rd     (rd_q),
        .i_rs1          (i_id_rs1),
        .i_rs2          (i_id_rs2),
        .i_rd           (i_id_rd),
        .i_rd_write     (i_id_rd_write),
        .o_hazard_c     (hazard_c)
    );

    function automatic value_t read_operand(
        input reg_idx_t                      rs,
        input logic                          ex_valid,
        input reg_idx_t                      ex_rd,
        input value_t                        ex_value,
        input logic [NUM_REGS-1:0][XLEN-1:0] rf
    );
        if (ex_valid && (ex_rd == rs) && (rs != '0)) begin
            return ex_value;
        end else if (rs == '0) begin
            return '0;
        end else begin
            return rf[rs];
        end
    endfunction

    always_comb begin
        id_ready_c  = !i_rst && !hazard_c && !i_flush && (!of_valid_q || i_of_ready);
        accept_c    = i_id_valid && id_ready_c;
        rs1_value_c = read_operand(i_id_rs1, i_ex_valid, i_ex_rd, i_ex_rd_value, i_register_file);
        rs2_value_c = read_operand(i_id_rs2, i_ex_valid, i_ex_rd, i_ex_rd_value, i_register_file);
    end

    // Flush beats everything; a stalled output (valid, !ready) keeps its contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            of_valid_q  <= 1'b0;
            rs1_value_q <= '0;
            rs2_value_q <= '0;
            rd_q        <= '0;
            rd_write_q  <= 1'b0;
        end else if (i_flush) begin
            of_valid_q  <= 1'b0;
        end else if (accept_c) begin
            of_valid_q  <= 1'b1;
            rs1_value_q <= rs1_value_c;
            rs2_value_q <= rs2_value_c;
            rd_q        <= i_id_rd;
            rd_write_q  <= i_id_rd_write;
        end else if (i_of_ready) begin
            of_valid_q  <= 1'b0;
        end
    end

    assign o_id_ready     = id_ready_c;
    assign o_of_valid     = of_valid_q;
    assign o_of_rs1_value = rs1_value_q;
    assign o_of_rs2_value = rs2_value_q;
    assign o_of_rd        = rd_q;
    assign o_of_rd_write  = rd_write_q;

endmodule

// File: tb/tb_rice_core_operand_fetch.sv
// Directed bench for rice_core_operand_fetch with a per-cycle reference model.
module tb_rice_core_operand_fetch;

    localparam int unsigned XLEN = 32;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_id_valid;
    logic                   o_id_ready;
    logic [4:0]             i_id_rs1;
    logic [4:0]             i_id_rs2;
    logic [4:0]             i_id_rd;
    logic                   i_id_rd_write;
    logic [31:0][XLEN-1:0]  i_register_file;
    logic                   i_ex_valid;
    logic [4:0]             i_ex_rd;
    logic [XLEN-1:0]        i_ex_rd_value;
    logic                   i_flush;
    logic                   o_of_valid;
    logic                   i_of_ready;
    logic [XLEN-1:0]        o_of_rs1_value;
    logic [XLEN-1:0]        o_of_rs2_value;
    logic [4:0]             o_of_rd;
    logic                   o_of_rd_write;

    always #5 i_clk = ~i_clk;

    rice_core_operand_fetch #(.XLEN(XLEN)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_id_valid      (i_id_valid),
        .o_id_ready      (o_id_ready),
        .i_id_rs1        (i_id_rs1),
        .i_id_rs2        (i_id_rs2),
        .i_id_rd         (i_id_rd),
        .i_id_rd_write   (i_id_rd_write),
        .i_register_file (i_register_file),
        .i_ex_valid      (i_ex_valid),
        .i_ex_rd         (i_ex_rd),
        .i_ex_rd_value   (i_ex_rd_value),
        .i_flush         (i_flush),
        .o_of_valid      (o_of_valid),
        .i_of_ready      (i_of_ready),
        .o_of_rs1_value  (o_of_rs1_value),
        .o_of_rs2_value  (o_of_rs2_value),
        .o_of_rd         (o_of_rd),
        .o_of_rd_write   (o_of_rd_write)
    );

    int errors = 0;
    int checks = 0;

    bit [31:0] rf [32];

    // Reference state: set of registers with an outstanding write, plus the held instruction.
    bit        busy_m [32];
    bit        m_valid;
    bit [31:0] m_rs1v;
    bit [31:0] m_rs2v;
    bit [4:0]  m_rd;
    bit        m_rdw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_operand(input bit [4:0] rs);
        if (i_ex_valid && i_ex_rd == rs && rs != 0) return i_ex_rd_value;
        if (rs == 0) return 32'h0;
        return rf[rs];
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = 1'b0;
        if (busy_m[i_id_rs1] && i_id_rs1 != 0 && !(i_ex_valid && i_ex_rd == i_id_rs1)) haz = 1'b1;
        if (busy_m[i_id_rs2] && i_id_rs2 != 0 && !(i_ex_valid && i_ex_rd == i_id_rs2)) haz = 1'b1;
        if (i_id_rd_write && i_id_rd != 0 && busy_m[i_id_rd] && !(i_ex_valid && i_ex_rd == i_id_rd)) haz = 1'b1;
        return !i_rst && !haz && !i_flush && (!m_valid || i_of_ready);
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        bit acc;
        if (i_rst) begin
            for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
            m_valid = 0; m_rs1v = 0; m_rs2v = 0; m_rd = 0; m_rdw = 0;
        end else begin
            acc = i_id_valid && m_ready();
            if (i_ex_valid && i_ex_rd != 0) busy_m[i_ex_rd] = 1'b0;
            if (i_flush && m_valid && m_rdw && m_rd != 0) busy_m[m_rd] = 1'b0;
            if (acc && i_id_rd_write && i_id_rd != 0) busy_m[i_id_rd] = 1'b1;
            if (i_flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_rs1v  = m_operand(i_id_rs1);
                m_rs2v  = m_operand(i_id_rs2);
                m_rd    = i_id_rd;
                m_rdw   = i_id_rd_write;
            end else if (i_of_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge i_clk) begin
        chk("of_valid", 64'(o_of_valid), 64'(m_valid));
        chk("id_ready", 64'(o_id_ready), 64'(m_ready()));
        if (m_valid) begin
            chk("rs1_value", 64'(o_of_rs1_value), 64'(m_rs1v));
            chk("rs2_value", 64'(o_of_rs2_value), 64'(m_rs2v));
            chk("rd", 64'(o_of_rd), 64'(m_rd));
            chk("rd_write", 64'(o_of_rd_write), 64'(m_rdw));
        end
    end

    task automatic drive_rf();
        for (int i = 0; i < 32; i++) i_register_file[i] = rf[i];
    endtask

    // Advance one cycle; an EX writeback lands in the register file at this edge.
    task automatic tick();
        bit        ev;
        bit [4:0]  er;
        bit [31:0] evv;
        ev = i_ex_valid; er = i_ex_rd; evv = i_ex_rd_value;
        @(posedge i_clk);
        #1;
        if (ev && er != 0) rf[er] = evv;
        drive_rf();
    endtask

    task automatic idle();
        i_id_valid = 0; i_ex_valid = 0; i_flush = 0;
        i_ex_rd = 0; i_ex_rd_value = 0;
    endtask

    task automatic issue(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd, input bit rdw);
        i_id_valid = 1; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd; i_id_rd_write = rdw;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        drive_rf();
        i_rst = 1; i_of_ready = 1;
        i_id_rs1 = 0; i_id_rs2 = 0; i_id_rd = 0; i_id_rd_write = 0;
        idle();
        i_id_valid = 1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_ready", 64'(o_id_ready), 64'd0);
        chk("reset_valid", 64'(o_of_valid), 64'd0);
        @(posedge i_clk);
        #1 i_rst = 0;
        idle();

        // Basic read of two registers.
        issue(1, 2, 0, 0);
        #1 chk("basic_ready", 64'(o_id_ready), 64'd1);
        tick(); idle();
        chk("basic_valid", 64'(o_of_valid), 64'd1);
        chk("basic_rs1", 64'(o_of_rs1_value), 64'd5);
        chk("basic_rs2", 64'(o_of_rs2_value), 64'd7);

        // RAW on x3: stall, then released by same-cycle forwarding.
        issue(0, 0, 3, 1);
        tick();
        issue(3, 0, 0, 0);
        #1 chk("raw_stall_ready", 64'(o_id_ready), 64'd0);
        tick();
        i_ex_valid = 1; i_ex_rd = 3; i_ex_rd_value = 32'h55;
        #1 chk("raw_fwd_ready", 64'(o_id_ready), 64'd1);
        tick(); idle();
        chk("raw_fwd_rs1", 64'(o_of_rs1_value), 64'h55);

        // x0 never forwards and never stalls.
        issue(0, 0, 0, 0);
        i_ex_valid = 1; i_ex_rd = 0; i_ex_rd_value = 32'hFF;
        #1 chk("x0_ready", 64'(o_id_ready), 64'd1);
        tick(); idle();
        chk("x0_rs1", 64'(o_of_rs1_value), 64'd0);
        chk("x0_rs2", 64'(o_of_rs2_value), 64'd0);

        // Backpressure holds the output stable.
        issue(1, 2, 6, 1);
        tick();
        i_of_ready = 0;
        issue(2, 1, 7, 1);
        repeat (3) begin
            #1 chk("bp_ready", 64'(o_id_ready), 64'd0);
            tick();
            chk("bp_hold_rs1", 64'(o_of_rs1_value), 64'd5);
            chk("bp_hold_rs2", 64'(o_of_rs2_value), 64'd7);
            chk("bp_hold_rd", 64'(o_of_rd), 64'd6);
        end
        i_of_ready = 1;
        #1 chk("bp_release_ready", 64'(o_id_ready), 64'd1);
        tick(); idle();
        chk("bp_next_rs1", 64'(o_of_rs1_value), 64'd7);
        chk("bp_next_rd", 64'(o_of_rd), 64'd7);
        tick();

        // Flush of a held x4 writer releases its reservation.
        issue(0, 0, 4, 1);
        tick();
        i_of_ready = 0; idle(); i_flush = 1;
        #1 chk("flush_ready", 64'(o_id_ready), 64'd0);
        tick();
        i_flush = 0;
        chk("flush_valid", 64'(o_of_valid), 64'd0);
        i_of_ready = 1;
        issue(4, 0, 0, 0);
        #1 chk("flush_rs4_ready", 64'(o_id_ready), 64'd1);
        tick(); idle();
        chk("flush_rs4_value", 64'(o_of_rs1_value), 64'h104);

        // Asynchronous reset while an x5 writer is stalled.
        issue(0, 0, 5, 1);
        tick();
        i_of_ready = 0; idle();
        tick();
        #2 i_rst = 1;
        #1;
        chk("arst_valid", 64'(o_of_valid), 64'd0);
        chk("arst_rs1", 64'(o_of_rs1_value), 64'd0);
        chk("arst_rs2", 64'(o_of_rs2_value), 64'd0);
        chk("arst_rd", 64'(o_of_rd), 64'd0);
        chk("arst_rdw", 64'(o_of_rd_write), 64'd0);
        chk("arst_ready", 64'(o_id_ready), 64'd0);
        @(posedge i_clk);
        #1 i_rst = 0;
        i_of_ready = 1;
        issue(5, 0, 0, 0);
        #1 chk("post_rst_ready", 64'(o_id_ready), 64'd1);
        tick(); idle();
        chk("post_rst_rs1", 64'(o_of_rs1_value), 64'h105);

        // Mixed traffic against the model.
        for (int n = 0; n < 80; n++) begin
            i_id_valid    = 1'($urandom_range(0, 1));
            i_id_rs1      = 5'($urandom_range(0, 7));
            i_id_rs2      = 5'($urandom_range(0, 7));
            i_id_rd       = 5'($urandom_range(0, 7));
            i_id_rd_write = 1'($urandom_range(0, 1));
            i_ex_valid    = ($urandom_range(0, 2) != 0);
            i_ex_rd       = 5'($urandom_range(0, 7));
            i_ex_rd_value = $urandom;
            i_of_ready    = ($urandom_range(0, 3) != 0);
            i_flush       = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rice_core_operand_fetch.md
RICE_CORE_OPERAND_FETCH -- requirements
Module: rice_core_operand_fetch

Interface
REQ-001 Parameter: XLEN, 32, data width of register values.
REQ-002 i_clk  input  1  sole clock; all state updates on posedge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_id_valid  input  1  decoded instruction present.
REQ-005 o_id_ready  output  1  instruction accepted this cycle when high with i_id_valid.
REQ-006 i_id_rs1, i_id_rs2  input  5 each  source register indices.
REQ-007 i_id_rd  input  5  destination index; i_id_rd_write  input  1  instruction writes rd.
REQ-008 i_register_file  input  32xXLEN  current architectural register values, entry 0 reads zero.
REQ-009 i_ex_valid  input  1; i_ex_rd  input  5; i_ex_rd_value  input  XLEN  writeback result, committed to the register file at the next posedge.
REQ-010 i_flush  input  1  discard held output instruction.
REQ-011 o_of_valid  output  1; i_of_ready  input  1  handshake toward EX.
REQ-012 o_of_rs1_value, o_of_rs2_value  output  XLEN; o_of_rd  output  5; o_of_rd_write  output  1.

Function
REQ-013 Accept = i_id_valid && o_id_ready; accepted instruction appears on o_of_* exactly 1 cycle later.
REQ-014 Scoreboard busy[31:1] SHALL hold one bit per register with a pending write; busy[0] SHALL read 0 always.
REQ-015 Forward hit for rsN: i_ex_valid && i_ex_rd == rsN && rsN != 0.
REQ-016 rsN value SHALL be i_ex_rd_value on forward hit, 0 when rsN == 0, else i_register_file[rsN].
REQ-017 Hazard SHALL be raised when any of: rs1 busy without forward hit; rs2 busy without forward hit; i_id_rd_write && rd != 0 && busy[rd] && !(i_ex_valid && i_ex_rd == rd).
REQ-018 o_id_ready = !hazard && !i_flush && (!o_of_valid || i_of_ready); combinational, no dependency on i_id_valid.
REQ-019 On accept with rd_write && rd != 0: busy[rd] set; on i_ex_valid with i_ex_rd != 0: busy[i_ex_rd] cleared; same register set and cleared same cycle: set wins.
REQ-020 Output register loads on accept; when o_of_valid && !i_of_ready, all o_of_* SHALL hold stable.
REQ-021 o_of_valid clears when i_of_ready high and no accept.
REQ-022 i_flush: o_of_valid cleared next cycle; busy bit of the discarded output instruction (if o_of_rd_write, o_of_rd != 0) cleared; no accept that cycle; EX clears still apply.
REQ-023 rd_write with rd == 0 SHALL never set scoreboard state; o_of_rd_write passes through unchanged.

Reset
REQ-024 Asserting i_rst SHALL immediately force o_of_valid=0, o_of_rs1_value=0, o_of_rs2_value=0, o_of_rd=0, o_of_rd_write=0, busy=0.
REQ-025 During reset o_id_ready SHALL be 0; first accept possible on first posedge after deassertion.
REQ-026 Reset mid-stall SHALL drop the held instruction; no pending state survives.

Structure
REQ-027 Value and register-index types come from rice_core_pkg via rice_core_define_types(XLEN); no new package types.
REQ-028 Scoreboard (set/clear/flush-clear, busy vector, hazard query) SHALL be sub-module rice_core_scoreboard; forwarding mux and output register stay in top.

Verification
REQ-029 Reset, then accept rs1=1,rs2=2 with rf[1]=5, rf[2]=7, i_of_ready=1 -> next cycle o_of_valid=1, values 5/7.
REQ-030 Accept rd=3 write; next instr rs1=3 while busy, no EX -> o_id_ready=0; then i_ex_valid rd=3 value 0x55 -> same cycle ready=1, o_of_rs1_value=0x55 next cycle.
REQ-031 rs1=0, rs2=0 with i_ex_valid rd=0 value 0xFF -> both outputs 0, no stall.
REQ-032 o_of_valid=1, i_of_ready=0 for 3 cycles -> o_of_* unchanged, o_id_ready=0; release -> next instruction issued.
REQ-033 Held instruction rd=4 write, i_flush=1 -> o_of_valid=0 next cycle, busy[4]=0, rs1=4 then accepted without stall.
REQ-034 Assert i_rst with busy[5]=1 and o_of_valid=1 -> all outputs 0 immediately, rs1=5 accepted after deassertion.
